// File: rtl/pri_dec_pkg.sv
// Shared constants, index type and one-hot helper for the queued index-to-one-hot decoder.
package pri_dec_pkg;

  localparam int unsigned DefaultIw    = 3;
  localparam int unsigned DefaultDepth = 4;
  localparam int unsigned DefaultOw    = 1 << DefaultIw;

  typedef logic [DefaultIw-1:0] idx_t;

  function automatic logic [DefaultOw-1:0] onehot(idx_t idx);
    logic [DefaultOw-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/pri_dec_fifo.sv
// Index FIFO: storage, wrapping pointers and occupancy count; full/empty derive from count only.
module pri_dec_fifo #(
  parameter int unsigned IW    = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [IW-1:0]            push_idx,
  input  logic                     pop,
  output logic [IW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [IW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; stale entries are hidden by count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_idx;
  end

  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign count = count_q;

endmodule

// File: rtl/pri_dec_q.sv
// Queued index-to-one-hot decoder with valid/ready on both sides.
// Optional sticky delivered-vector mask when PRI_DEC_MASK_EN is defined.
module pri_dec_q
  import pri_dec_pkg::*;
#(
  parameter int unsigned IW    = DefaultIw,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned OW   = 1 << IW,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  output logic          in_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_onehot,
  input  logic          out_ready,
  output logic [CW-1:0] count
`ifdef PRI_DEC_MASK_EN
  ,
  output logic [OW-1:0] mask,
  input  logic          mask_clr
`endif
);

  logic          push;
  logic          pop;
  logic [IW-1:0] head;
  logic [OW-1:0] head_dec;

  pri_dec_fifo #(
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_idx (in_idx),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  // Handshake flags come from the count register only, never from the opposite side's inputs.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  if (IW == DefaultIw) begin : g_pkg_dec
    assign head_dec = onehot(idx_t'(head));
  end else begin : g_gen_dec
    assign head_dec = OW'(1) << head;
  end

  assign out_onehot = out_valid ? head_dec : '0;

`ifdef PRI_DEC_MASK_EN
  logic [OW-1:0] mask_q, mask_d;

  // Clear applies before the popped vector is merged in.
  always_comb begin
    mask_d = mask_q;
    if (mask_clr) mask_d = '0;
    if (pop)      mask_d = mask_d | out_onehot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  assign mask = mask_q;
`endif

endmodule
